spwm_phase_sequencer: RTL

- Drives the three-phase comparison-value table: owns its 16-bit address, advances it once per carrier period from a phase accumulator, and consumes the three 4-bit phase values returned (phases 120° apart).
- Compares each value against a 4-bit triangular carrier to produce complementary high/low gate signals with dead time, one pair per phase.
- Sits between the control logic (enable, frequency word) and the power-stage gate outputs.

---
 rtl/spwm_phase_sequencer_if.sv | 11 +
 rtl/spwm_phase_sequencer.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/spwm_phase_sequencer_if.sv
// rtl/spwm_phase_sequencer_if.sv - comparison-value table port between sequencer and table
interface spwm_phase_sequencer_if;
  logic        rom_en;
  logic [15:0] rom_addr;
  logic [3:0]  val1;
  logic [3:0]  val2;
  logic [3:0]  val3;

  modport master (output rom_en, rom_addr, input val1, val2, val3);
  modport slave  (input rom_en, rom_addr, output val1, val2, val3);
endinterface

// File: rtl/spwm_phase_sequencer.sv
// rtl/spwm_phase_sequencer.sv - three-phase sine-PWM sequencer with triangular carrier and dead time
module spwm_phase_sequencer #(
  parameter int ACC_WIDTH   = 24,
  parameter int DEAD_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [ACC_WIDTH-1:0] fcw,
  input  logic                 fcw_load,
  spwm_phase_sequencer_if.master rom,
  output logic [2:0]           pwm_hi,
  output logic [2:0]           pwm_lo,
  output logic                 sync,
  output logic                 running
);

  typedef enum logic {IDLE, RUN} ctl_t;
  typedef enum logic [1:0] {LOW_ON, DEAD_TO_HI, HI_ON, DEAD_TO_LO} phase_t;

  localparam logic [3:0] DEAD_INIT = 4'(DEAD_CYCLES - 1);

  ctl_t                 ctl_state;
  logic [3:0]           carrier;
  logic                 down;
  logic [ACC_WIDTH-1:0] acc;
  logic [ACC_WIDTH-1:0] fcw_shadow;
  logic [ACC_WIDTH-1:0] fcw_active;
  logic                 load_pending;
  logic [15:0]          addr;
  logic [3:0]           ref_val [3];
  logic [3:0]           val     [3];
  phase_t               ph      [3];
  phase_t               ph_next [3];
  logic [3:0]           cnt     [3];
  logic [3:0]           cnt_next[3];
  logic [2:0]           raw;
  logic                 period_start;
  logic                 advance;
  logic [ACC_WIDTH-1:0] acc_next;

  assign running      = (ctl_state == RUN);
  assign period_start = running && (carrier == 4'd0);
  assign sync         = period_start;
  assign advance      = running && en;
  assign rom.rom_en   = running;
  assign rom.rom_addr = addr;
  assign val[0]       = rom.val1;
  assign val[1]       = rom.val2;
  assign val[2]       = rom.val3;

  // A pending load takes effect on the very increment that applies it.
  assign acc_next = acc + (load_pending ? fcw_shadow : fcw_active);

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      raw[i]      = (ref_val[i] > carrier);
      ph_next[i]  = ph[i];
      cnt_next[i] = cnt[i];
      if (!advance) begin
        ph_next[i]  = LOW_ON;
        cnt_next[i] = 4'd0;
      end else begin
        case (ph[i])
          LOW_ON: if (raw[i]) begin
            ph_next[i]  = DEAD_TO_HI;
            cnt_next[i] = DEAD_INIT;
          end
          DEAD_TO_HI:
            if (!raw[i])            ph_next[i]  = LOW_ON;
            else if (cnt[i] == 4'd0) ph_next[i] = HI_ON;
            else                    cnt_next[i] = cnt[i] - 4'd1;
          HI_ON: if (!raw[i]) begin
            ph_next[i]  = DEAD_TO_LO;
            cnt_next[i] = DEAD_INIT;
          end
          DEAD_TO_LO:
            if (raw[i])             ph_next[i]  = HI_ON;
            else if (cnt[i] == 4'd0) ph_next[i] = LOW_ON;
            else                    cnt_next[i] = cnt[i] - 4'd1;
          default: ph_next[i] = LOW_ON;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctl_state    <= IDLE;
      carrier      <= 4'd0;
      down         <= 1'b0;
      acc          <= '0;
      fcw_shadow   <= '0;
      fcw_active   <= '0;
      load_pending <= 1'b0;
      addr         <= 16'd0;
      pwm_hi       <= 3'b000;
      pwm_lo       <= 3'b000;
      for (int i = 0; i < 3; i++) begin
        ref_val[i] <= 4'd0;
        ph[i]      <= LOW_ON;
        cnt[i]     <= 4'd0;
      end
    end else begin
      ctl_state <= en ? RUN : IDLE;

      if (advance) begin
        if (!down) begin
          if (carrier == 4'd15) begin
            carrier <= 4'd14;
            down    <= 1'b1;
          end else begin
            carrier <= carrier + 4'd1;
          end
        end else begin
          carrier <= carrier - 4'd1;
          if (carrier == 4'd1) down <= 1'b0;
        end
      end else begin
        carrier <= 4'd0;
        down    <= 1'b0;
      end

      if (period_start) begin
        acc  <= acc_next;
        addr <= acc_next[ACC_WIDTH-1 -: 16];
        if (load_pending) fcw_active <= fcw_shadow;
      end

      // A load on a period-start cycle must survive that boundary's clear.
      if (fcw_load) begin
        fcw_shadow   <= fcw;
        load_pending <= 1'b1;
      end else if (period_start) begin
        load_pending <= 1'b0;
      end

      if (running && carrier == 4'd15 && !down) begin
        for (int i = 0; i < 3; i++) ref_val[i] <= val[i];
      end

      for (int i = 0; i < 3; i++) begin
        ph[i]     <= ph_next[i];
        cnt[i]    <= cnt_next[i];
        pwm_hi[i] <= en && (ph_next[i] == HI_ON);
        pwm_lo[i] <= en && (ph_next[i] == LOW_ON);
      end
    end
  end

endmodule
